multiplicador_algoritmico: RTL and testbench
============================================

Name: multiplicador_algoritmico

Overview:
- Sequential signed shift-and-add multiplier. It is the multiplicative counterpart of the team's sequential restoring divider and uses the same Start/Done handshake.
- It multiplies two two's-complement operands over multiple cycles and returns the full-width signed product.
- It sits beside the divider in the arithmetic unit and is driven by the same controller.

Parameters:
- tamanyo, 32, operand width in bits (≥ 4). The product is 2*tamanyo bits.

Ports:
- CLK  input  1  system clock, rising edge.
- RSTa  input  1  asynchronous active-low reset.
- Start  input  1  request; sampled only in state IDLE.
- A  input  tamanyo  multiplicand, two's complement.
- B  input  tamanyo  multiplier, two's complement.
- Prod  output  2*tamanyo  signed product, registered.
- Busy  output  1  high in every state other than IDLE.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (RSTa=0, asynchronous):
  - state=IDLE; Prod=0; Done=0; Busy=0.
  - Internal ACC, Q, M, CONT, Sign and carry are all cleared.
- State register: IDLE, ADD, SHIFT, FIN.
- IDLE:
  - Done<=0.
  - If Start=1:
    - Sign<=A[msb]^B[msb].
    - Q<=|A|, M<=|B|, taken as unsigned magnitudes.
    - ACC<=0, C<=0, CONT<=tamanyo-1.
    - Go to ADD.
  - Otherwise stay in IDLE.
- ADD:
  - If Q[0]=1: {C,ACC}<=ACC+M, computed at tamanyo+1 bits so the carry is kept.
  - Otherwise hold ACC and clear C.
  - Go to SHIFT.
- SHIFT:
  - {C,ACC,Q}<={C,ACC,Q}>>1 (logical); CONT<=CONT-1.
  - If CONT==0 go to FIN; otherwise go to ADD.
- FIN:
  - Prod<= Sign ? (~{ACC,Q}+1) : {ACC,Q}.
  - Done<=1; go to IDLE.
- Latency:
  - Start is sampled at edge E0.
  - Done and the new Prod are visible after edge E0+2*tamanyo+1, i.e. 2*tamanyo+1 cycles.
  - Done stays high for exactly one cycle.
- Prod holds its value until the next FIN. It is never cleared by Start.
- Start while Busy=1 is ignored. There is no queuing and no abort.
- Start=1 in the IDLE cycle where Done=1 starts a new operation immediately:
  - Done drops at the next edge.
  - Prod keeps the previous result until the new FIN.
- A and B are sampled only at the Start edge. Later changes do not affect the operation in progress.
- Width rules:
  - Magnitudes are unsigned tamanyo bits, so |−2^(tamanyo−1)|=2^(tamanyo−1) is represented exactly.
  - Product magnitude ≤ 2^(2*tamanyo−2), so there is no overflow.
  - Negation is done at 2*tamanyo bits.
- Zero operand with a negative sign must produce Prod=0. This follows from ~0+1 wrapping to 0.
- Reset asserted mid-operation aborts immediately to the reset values. No Done is produced.
- Busy is decoded combinationally as (state!=IDLE).

Test Plan (tamanyo=8):
- Multiply by negative: A=7, B=-3, pulse Start → Busy high for 17 cycles; Done pulses once at cycle 17; Prod=16'hFFEB (−21); Prod holds afterwards.
- Largest negative squared: A=-128, B=-128 → Prod=16'h4000 (16384). Then A=-128, B=127 → Prod=16'hC080 (−16256).
- Zero and maximum: A=0, B=-5 → Prod=16'h0000. A=127, B=127 → Prod=16'h3F01 (16129).
- Ignored Start and operand hold: start A=5, B=6; at cycle 4 raise Start with A=9, B=9 and also change A and B → Done only at cycle 17; Prod=16'h001E (30); no second Done.
- Back-to-back: hold Start=1 continuously with A=3, B=-4, then A=-2, B=-2 → Done pulses at cycles 17 and 35; Prod=16'hFFF4 (−12), then 16'h0004 (4).
- Reset mid-operation: assert RSTa=0 at cycle 6 of a 7*7 multiply → Prod=0, Done=0 and Busy=0 immediately. After release, a new Start with A=2, B=3 gives Prod=6 after 17 cycles.

Source files
------------

// File: rtl/multiplicador_algoritmico_if.sv
// Start/Done handshake bundle shared by the arithmetic-unit controller and the
// sequential signed multiplier.
interface multiplicador_algoritmico_if #(
  parameter int unsigned tamanyo = 32
);
  logic                   Start;
  logic [tamanyo-1:0]     A;
  logic [tamanyo-1:0]     B;
  logic [2*tamanyo-1:0]   Prod;
  logic                   Busy;
  logic                   Done;

  modport master (
    output Start,
    output A,
    output B,
    input  Prod,
    input  Busy,
    input  Done
  );

  modport slave (
    input  Start,
    input  A,
    input  B,
    output Prod,
    output Busy,
    output Done
  );
endinterface

// File: rtl/multiplicador_algoritmico.sv
// Sequential signed shift-and-add multiplier: multiplies operand magnitudes one
// bit per ADD/SHIFT pair, then applies the sign to the 2*tamanyo-bit result.
module multiplicador_algoritmico #(
  parameter int unsigned tamanyo = 32
) (
  input  logic                          CLK,
  input  logic                          RSTa,
  multiplicador_algoritmico_if.slave    bus
);

  localparam int unsigned anchocont = $clog2(tamanyo);
  localparam logic [anchocont-1:0] cont_ini = anchocont'(tamanyo - 1);
  localparam logic [tamanyo-1:0]   uno      = {{(tamanyo-1){1'b0}}, 1'b1};
  localparam logic [2*tamanyo-1:0] uno_doble = {{(2*tamanyo-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StAdd, StShift, StFin} estado_e;

  estado_e                estado;
  logic [tamanyo-1:0]     acc;
  logic [tamanyo-1:0]     q;
  logic [tamanyo-1:0]     m;
  logic                   c;
  logic                   sign;
  logic [anchocont-1:0]   cont;
  logic [2*tamanyo-1:0]   prod;
  logic                   done;

  logic [tamanyo-1:0]     mag_a;
  logic [tamanyo-1:0]     mag_b;
  logic [tamanyo:0]       suma;
  logic [2*tamanyo-1:0]   prod_neg;

  // Unsigned magnitudes: the most negative operand maps to 2^(tamanyo-1) exactly.
  assign mag_a    = bus.A[tamanyo-1] ? (~bus.A + uno) : bus.A;
  assign mag_b    = bus.B[tamanyo-1] ? (~bus.B + uno) : bus.B;
  assign suma     = {1'b0, acc} + {1'b0, m};
  assign prod_neg = ~{acc, q} + uno_doble;

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      estado <= StIdle;
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      c      <= 1'b0;
      sign   <= 1'b0;
      cont   <= '0;
      prod   <= '0;
      done   <= 1'b0;
    end else begin
      unique case (estado)
        StIdle: begin
          done <= 1'b0;
          if (bus.Start) begin
            sign   <= bus.A[tamanyo-1] ^ bus.B[tamanyo-1];
            q      <= mag_a;
            m      <= mag_b;
            acc    <= '0;
            c      <= 1'b0;
            cont   <= cont_ini;
            estado <= StAdd;
          end
        end
        StAdd: begin
          if (q[0]) begin
            {c, acc} <= suma;
          end else begin
            c <= 1'b0;
          end
          estado <= StShift;
        end
        StShift: begin
          // Logical right shift of {c, acc, q}; the carry re-enters acc's MSB.
          c    <= 1'b0;
          acc  <= {c, acc[tamanyo-1:1]};
          q    <= {acc[0], q[tamanyo-1:1]};
          cont <= cont - 1'b1;
          estado <= (cont == '0) ? StFin : StAdd;
        end
        StFin: begin
          // Zero magnitude with negative sign wraps back to zero here.
          prod   <= sign ? prod_neg : {acc, q};
          done   <= 1'b1;
          estado <= StIdle;
        end
      endcase
    end
  end

  assign bus.Prod = prod;
  assign bus.Done = done;
  assign bus.Busy = (estado != StIdle);

endmodule

// File: tb/tb_multiplicador_algoritmico.sv
// Randomised scoreboard bench for the sequential signed multiplier at tamanyo=8.
module tb_multiplicador_algoritmico;

  localparam int unsigned W   = 8;
  localparam int          LAT = 2 * W + 1;

  logic CLK  = 1'b0;
  logic RSTa = 1'b0;

  always #5 CLK = ~CLK;

  multiplicador_algoritmico_if #(.tamanyo(W)) bus ();

  multiplicador_algoritmico #(.tamanyo(W)) dut (
    .CLK  (CLK),
    .RSTa (RSTa),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb[$];

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sbv;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    return (2*W)'(sa * sbv);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding expectation.
  logic done_prev = 1'b0;
  always @(negedge CLK) begin
    if (bus.Done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        check("prod", 64'(bus.Prod), 64'(sb.pop_front()));
      end
      check("done_pulse", 64'(done_prev), 64'd0);
    end
    done_prev <= bus.Done;
  end

  // Called #1 after the accepting edge; returns cycles until Done and Busy samples seen.
  task automatic wait_done(input bit glitch, output int cyc, output int busy);
    cyc  = 0;
    busy = 0;
    while (!bus.Done && cyc < 200) begin
      if (bus.Busy) busy++;
      if (glitch && cyc == 4) begin
        bus.Start = 1'b1; bus.A = 8'd9; bus.B = 8'd9;
      end
      if (glitch && cyc == 5) begin
        bus.Start = 1'b0; bus.A = 8'h55; bus.B = 8'hAA;
      end
      @(posedge CLK); #1;
      cyc++;
    end
    if (!bus.Done) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d required=%0d", cyc, LAT);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.A     = a;
    bus.B     = b;
    bus.Start = 1'b1;
    sb.push_back(model(a, b));
    @(posedge CLK); #1;
    bus.Start = 1'b0;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit glitch);
    int cyc;
    int busy;
    logic [2*W-1:0] exp;
    exp = model(a, b);
    start_op(a, b);
    wait_done(glitch, cyc, busy);
    check("latency", 64'(cyc), 64'(LAT));
    check("busy_cycles", 64'(busy), 64'(LAT));
    check("busy_at_done", 64'(bus.Busy), 64'd0);
    repeat (3) begin
      @(posedge CLK); #1;
    end
    check("prod_hold", 64'(bus.Prod), 64'(exp));
    check("done_low", 64'(bus.Done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cyc;
    int busy;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    bus.Start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #2;
    check("reset_prod", 64'(bus.Prod), 64'd0);
    check("reset_done", 64'(bus.Done), 64'd0);
    check("reset_busy", 64'(bus.Busy), 64'd0);
    @(negedge CLK);
    RSTa = 1'b1;
    @(posedge CLK); #1;

    do_op(8'd7, 8'hFD, 1'b0);           // 7 * -3 = -21
    do_op(8'h80, 8'h80, 1'b0);          // -128 squared
    do_op(8'h80, 8'd127, 1'b0);
    do_op(8'd0, 8'hFB, 1'b0);           // zero with negative sign
    do_op(8'd127, 8'd127, 1'b0);
    do_op(8'd5, 8'd6, 1'b1);            // Start while busy is ignored
    repeat (LAT + 4) begin
      @(posedge CLK); #1;
    end
    check("no_second_op", 64'(bus.Busy), 64'd0);

    // Back-to-back with Start held high.
    bus.A = 8'd3; bus.B = 8'hFC; bus.Start = 1'b1;
    sb.push_back(model(8'd3, 8'hFC));
    @(posedge CLK); #1;
    wait_done(1'b0, cyc, busy);
    check("b2b_first_latency", 64'(cyc), 64'(LAT));
    bus.A = 8'hFE; bus.B = 8'hFE;
    sb.push_back(model(8'hFE, 8'hFE));
    @(posedge CLK); #1;
    check("b2b_done_drop", 64'(bus.Done), 64'd0);
    check("b2b_prod_kept", 64'(bus.Prod), 64'(model(8'd3, 8'hFC)));
    wait_done(1'b0, cyc, busy);
    bus.Start = 1'b0;
    check("b2b_second_latency", 64'(cyc + LAT + 1), 64'(2 * LAT + 1));
    repeat (3) begin
      @(posedge CLK); #1;
    end
    check("b2b_prod_hold", 64'(bus.Prod), 64'(model(8'hFE, 8'hFE)));

    // Reset in the middle of 7*7.
    start_op(8'd7, 8'd7);
    repeat (5) begin
      @(posedge CLK); #1;
    end
    RSTa = 1'b0;
    #1;
    check("abort_prod", 64'(bus.Prod), 64'd0);
    check("abort_done", 64'(bus.Done), 64'd0);
    check("abort_busy", 64'(bus.Busy), 64'd0);
    sb.delete();
    @(negedge CLK);
    RSTa = 1'b1;
    @(posedge CLK); #1;
    do_op(8'd2, 8'd3, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(ra, rb, 1'b0);
    end

    repeat (5) @(posedge CLK);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
